// File: rtl/w_stage_grf_pkg.sv
// Shared definitions for the write-back stage: write-back source encodings,
// register-file geometry and datapath width.
`default_nettype none

package w_stage_grf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_DM  = 2'b01,
        WB_SEL_PC8 = 2'b10,
        WB_SEL_MDU = 2'b11
    } wb_sel_e;

endpackage

`default_nettype wire

// File: rtl/w_stage_grf_core.sv
// ---------------------------------------------------------------------------
// Module  : grf_core
// Purpose : 32-entry register file, async clear, $0 hard-wired to zero,
//           two combinational read ports. Optional write-to-read bypass
//           enabled by macro GRF_BYPASS_EN.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module grf_core
    import w_stage_grf_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    logic [DATA_W-1:0] r_regs [0:REG_NUM-1];
    logic              w_we_eff;

    assign w_we_eff = we && (waddr != REG_ZERO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_eff) begin
            r_regs[waddr] <= wdata;
        end
    end

    // While reset is held the array is cleared, so reads must not expose
    // the bypass path either.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (!reset) begin
            if (raddr1 != REG_ZERO) begin
                rdata1 = r_regs[raddr1];
`ifdef GRF_BYPASS_EN
                if (w_we_eff && (raddr1 == waddr)) begin
                    rdata1 = wdata;
                end
`endif
            end
            if (raddr2 != REG_ZERO) begin
                rdata2 = r_regs[raddr2];
`ifdef GRF_BYPASS_EN
                if (w_we_eff && (raddr2 == waddr)) begin
                    rdata2 = wdata;
                end
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/w_stage_grf.sv
// ---------------------------------------------------------------------------
// Module  : w_stage_grf
// Purpose : MIPS write-back stage: source mux, GRF commit, D-stage reads,
//           committed-write counter. Macro GRF_BYPASS_EN selects the GRF
//           write-to-read bypass.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module w_stage_grf
    import w_stage_grf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_NUM   = 32,
    parameter int PC_OFFSET = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  W_WriteRegAddr,
    input  logic [31:0] W_ALU_out,
    input  logic [31:0] W_DM_out,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_MDU_out,
    input  logic        W_CU_EN_RegWrite,
    input  logic [1:0]  W_CU_GRFWriteData_Sel,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    output logic [31:0] D_rs_data,
    output logic [31:0] D_rt_data,
    output logic [31:0] W_WriteData,
    output logic [31:0] W_commit_cnt,
    output logic        dbg_we,
    output logic [31:0] dbg_pc
);

    logic [DATA_W-1:0] w_write_data;
    logic              w_we_eff;
    logic [31:0]       r_commit_cnt;

    always_comb begin
        w_write_data = W_ALU_out;
        case (wb_sel_e'(W_CU_GRFWriteData_Sel))
            WB_SEL_ALU: w_write_data = W_ALU_out;
            WB_SEL_DM:  w_write_data = W_DM_out;
            WB_SEL_PC8: w_write_data = W_PC + DATA_W'(PC_OFFSET);
            WB_SEL_MDU: w_write_data = W_MDU_out;
            default:    w_write_data = W_ALU_out;
        endcase
    end

    assign w_we_eff = W_CU_EN_RegWrite && (W_WriteRegAddr != REG_ZERO);

    // Counter wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_commit_cnt <= '0;
        end else if (w_we_eff) begin
            r_commit_cnt <= r_commit_cnt + 32'd1;
        end
    end

    grf_core #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM)
    ) u_grf_core (
        .clk    (clk),
        .reset  (reset),
        .we     (W_CU_EN_RegWrite),
        .waddr  (W_WriteRegAddr),
        .wdata  (w_write_data),
        .raddr1 (D_rs_addr),
        .raddr2 (D_rt_addr),
        .rdata1 (D_rs_data),
        .rdata2 (D_rt_data)
    );

    assign W_WriteData  = w_write_data;
    assign W_commit_cnt = r_commit_cnt;
    assign dbg_we       = w_we_eff;
    assign dbg_pc       = W_PC;

endmodule

`default_nettype wire

// File: tb/tb_w_stage_grf.sv
// Randomized scoreboard bench for w_stage_grf with an array-based reference
// model; the model honours GRF_BYPASS_EN the same way the build does.
`timescale 1ns/100ps
`default_nettype none

module tb_w_stage_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  W_WriteRegAddr;
    logic [31:0] W_ALU_out, W_DM_out, W_PC, W_MDU_out;
    logic        W_CU_EN_RegWrite;
    logic [1:0]  W_CU_GRFWriteData_Sel;
    logic [4:0]  D_rs_addr, D_rt_addr;
    logic [31:0] D_rs_data, D_rt_data, W_WriteData, W_commit_cnt, dbg_pc;
    logic        dbg_we;

    w_stage_grf dut (
        .clk                   (clk),
        .reset                 (reset),
        .W_WriteRegAddr        (W_WriteRegAddr),
        .W_ALU_out             (W_ALU_out),
        .W_DM_out              (W_DM_out),
        .W_PC                  (W_PC),
        .W_MDU_out             (W_MDU_out),
        .W_CU_EN_RegWrite      (W_CU_EN_RegWrite),
        .W_CU_GRFWriteData_Sel (W_CU_GRFWriteData_Sel),
        .D_rs_addr             (D_rs_addr),
        .D_rt_addr             (D_rt_addr),
        .D_rs_data             (D_rs_data),
        .D_rt_data             (D_rt_data),
        .W_WriteData           (W_WriteData),
        .W_commit_cnt          (W_commit_cnt),
        .dbg_we                (dbg_we),
        .dbg_pc                (dbg_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        we;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One transaction: inputs held from one falling edge to the next, so
    // exactly one rising edge sees them.
    task automatic txn(input bit rst, input bit we, input logic [4:0] wa, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc,
                       input logic [31:0] mdu, input logic [4:0] rs, input logic [4:0] rt);
        exp_t        e;
        logic [31:0] wd;
        bit          weff;
        @(negedge clk);
        reset = rst;
        W_CU_EN_RegWrite = we;  W_WriteRegAddr = wa;  W_CU_GRFWriteData_Sel = sel;
        W_ALU_out = alu;  W_DM_out = dm;  W_PC = pc;  W_MDU_out = mdu;
        D_rs_addr = rs;  D_rt_addr = rt;
        case (sel)
            2'd0:    wd = alu;
            2'd1:    wd = dm;
            2'd2:    wd = pc + 32'd8;
            default: wd = mdu;
        endcase
        weff = we && (wa != 5'd0);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_cnt = 32'd0;
        end
        e.rs = (rs == 5'd0) ? 32'd0 : m_regs[rs];
        e.rt = (rt == 5'd0) ? 32'd0 : m_regs[rt];
`ifdef GRF_BYPASS_EN
        if (!rst && weff && rs == wa && rs != 5'd0) e.rs = wd;
        if (!rst && weff && rt == wa && rt != 5'd0) e.rt = wd;
`endif
        e.wd  = wd;
        e.pc  = pc;
        e.cnt = m_cnt;
        e.we  = weff;
        sb_q.push_back(e);
        if (!rst && weff) begin
            m_regs[wa] = wd;
            m_cnt      = m_cnt + 32'd1;
        end
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        txn(0, 0, 5'd0, 2'd0, 32'd0, 32'd0, 32'h100, 32'd0, rs, rt);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("D_rs_data",    D_rs_data,            e.rs);
                check("D_rt_data",    D_rt_data,            e.rt);
                check("W_WriteData",  W_WriteData,          e.wd);
                check("dbg_pc",       dbg_pc,               e.pc);
                check("W_commit_cnt", W_commit_cnt,         e.cnt);
                check("dbg_we",       {31'd0, dbg_we},      {31'd0, e.we});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b1;
        W_CU_EN_RegWrite = 0; W_WriteRegAddr = 0; W_CU_GRFWriteData_Sel = 0;
        W_ALU_out = 0; W_DM_out = 0; W_PC = 0; W_MDU_out = 0;
        D_rs_addr = 0; D_rt_addr = 0;
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_cnt = 32'd0;

        // Reset state, then a pre-load that an async pulse must wipe.
        txn(1, 0, 5'd0, 2'd0, 0, 0, 0, 0, 5'd5, 5'd0);
        txn(0, 1, 5'd5, 2'd0, 32'h55, 0, 0, 0, 5'd5, 5'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_cnt", W_commit_cnt, 32'd0);
        check("async_rd5", D_rs_data, 32'd0);
        #1;
        reset = 1'b0;
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
        W_CU_EN_RegWrite = 1'b0;

        // Write-back select sweep on reg 8.
        for (int s = 0; s < 4; s++) begin
            txn(0, 1, 5'd8, 2'(s), 32'h11, 32'h22, 32'h3000, 32'h44, 5'd8, 5'd8);
        end
        idle(5'd8, 5'd0);

        // $0 guard.
        txn(0, 1, 5'd0, 2'd0, 32'hDEADBEEF, 0, 0, 0, 5'd0, 5'd8);
        idle(5'd0, 5'd0);

        // Read during write on reg 9.
        txn(0, 1, 5'd9, 2'd0, 32'h1, 0, 0, 0, 5'd0, 5'd0);
        txn(0, 1, 5'd9, 2'd0, 32'h2, 0, 0, 0, 5'd9, 5'd9);
        idle(5'd9, 5'd9);

        // Counter wrap: preset the counter after the monitor sample.
        idle(5'd9, 5'd8);
        #4;
        force dut.r_commit_cnt = 32'hFFFF_FFFF;
        #0.5;
        release dut.r_commit_cnt;
        m_cnt = 32'hFFFF_FFFF;
        txn(0, 1, 5'd3, 2'd3, 0, 0, 0, 32'hABCD, 5'd3, 5'd0);
        txn(0, 0, 5'd4, 2'd0, 32'h77, 0, 0, 0, 5'd3, 5'd4);

        // Reset held across an active write edge; write resumes afterwards.
        txn(0, 1, 5'd11, 2'd0, 32'h0BAD, 0, 0, 0, 5'd11, 5'd0);
        txn(1, 1, 5'd10, 2'd1, 0, 32'hCAFE, 0, 0, 5'd10, 5'd11);
        txn(0, 1, 5'd10, 2'd2, 0, 0, 32'hFFFF_FFFC, 0, 5'd10, 5'd11);
        idle(5'd10, 5'd11);

        // Randomized traffic, with occasional reset cycles.
        for (int n = 0; n < 400; n++) begin
            txn(($urandom_range(0, 59) == 0), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                $urandom, $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        repeat (2) @(negedge clk);
        #4;
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
